// File: rtl/sisc_ctrl_pkg.sv
// sisc_ctrl_pkg: shared definitions for the SISC multicycle controller.
//   - state_e      : controller state encoding (3-bit)
//   - OP_*         : opcode values of instr[31:28]
//   - WB_*         : writeback mux select codes
//   - ALU_*        : alu_op codes
//   - branch helpers used by the control FSM
package sisc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_e;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_ALU_RR  = 4'h1;
  localparam logic [3:0] OP_ALU_IMM = 4'h2;
  localparam logic [3:0] OP_BRA     = 4'h3;
  localparam logic [3:0] OP_BRR     = 4'h4;
  localparam logic [3:0] OP_BNE     = 4'h5;
  localparam logic [3:0] OP_BNR     = 4'h6;
  localparam logic [3:0] OP_LOD     = 4'h8;
  localparam logic [3:0] OP_STR     = 4'hC;
  localparam logic [3:0] OP_HLT     = 4'hF;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;

  localparam logic [1:0] ALU_PASS  = 2'b00;
  localparam logic [1:0] ALU_ARITH = 2'b01;
  localparam logic [1:0] ALU_LOGIC = 2'b10;

  // BRA/BNE use the immediate as an absolute target.
  function automatic logic is_abs_branch(input logic [3:0] op);
    return (op == OP_BRA) || (op == OP_BNE);
  endfunction

  // BNE/BNR branch when no masked status bit is set.
  function automatic logic is_neg_branch(input logic [3:0] op);
    return (op == OP_BNE) || (op == OP_BNR);
  endfunction

endpackage

// File: rtl/sisc_ctrl_if.sv
// sisc_ctrl_if: bundle between the SISC controller and its datapath.
//   opcode/mm : instruction register fields (datapath -> controller)
//   stat      : status register {C,V,N,Z}   (datapath -> controller)
//   ir_load, pc_write, pc_sel, br_sel, alu_op, stat_en, rf_we, wb_sel,
//   dm_we, halted : controller -> datapath enables/selects
// Modports: master = controller side, slave = datapath side.
interface sisc_ctrl_if #(
  parameter int OP_W   = 4,
  parameter int MM_W   = 4,
  parameter int STAT_W = 4
);

  logic [OP_W-1:0]   opcode;
  logic [MM_W-1:0]   mm;
  logic [STAT_W-1:0] stat;
  logic              ir_load;
  logic              pc_write;
  logic              pc_sel;
  logic              br_sel;
  logic [1:0]        alu_op;
  logic              stat_en;
  logic              rf_we;
  logic [1:0]        wb_sel;
  logic              dm_we;
  logic              halted;

  modport master (
    input  opcode, mm, stat,
    output ir_load, pc_write, pc_sel, br_sel, alu_op, stat_en,
           rf_we, wb_sel, dm_we, halted
  );

  modport slave (
    output opcode, mm, stat,
    input  ir_load, pc_write, pc_sel, br_sel, alu_op, stat_en,
           rf_we, wb_sel, dm_we, halted
  );

endinterface

// File: rtl/sisc_ctrl_br_eval.sv
// sisc_ctrl_br_eval: combinational branch-taken evaluation.
//   mm_i    : condition mask from the latched instruction
//   stat_i  : current status register {C,V,N,Z}
//   neg_i   : 1 for BNE/BNR (branch when no masked bit is set)
//   taken_o : branch decision
// A zero mask never matches, so BRA/BRR never take and BNE/BNR always take.
module sisc_ctrl_br_eval #(
  parameter int MM_W   = 4,
  parameter int STAT_W = 4
) (
  input  logic [MM_W-1:0]   mm_i,
  input  logic [STAT_W-1:0] stat_i,
  input  logic              neg_i,
  output logic              taken_o
);

  logic hit;

  always_comb begin
    hit     = |(mm_i & stat_i);
    taken_o = neg_i ? ~hit : hit;
  end

endmodule

// File: rtl/sisc_ctrl.sv
// sisc_ctrl: multicycle control FSM for the 16-bit SISC datapath.
// Sequences FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB] -> FETCH and is the
// sole source of datapath enables.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : sisc_ctrl_if.master (opcode/mm/stat in; all enables/selects out)
// Outputs are Moore, decoded from the state and the opcode/mm latched in
// DECODE; only pc_sel/pc_write/br_sel in EXECUTE look at stat (branches).
module sisc_ctrl
  import sisc_ctrl_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int MM_W   = 4,
  parameter int STAT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  sisc_ctrl_if.master bus
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] opcode_q;
  logic [MM_W-1:0] mm_q;

  logic       taken;
  logic [1:0] alu_fn;

  logic       ir_load_d, pc_write_d, pc_sel_d, br_sel_d;
  logic [1:0] alu_op_d, wb_sel_d;
  logic       stat_en_d, rf_we_d, dm_we_d, halted_d;

  sisc_ctrl_br_eval #(
    .MM_W   (MM_W),
    .STAT_W (STAT_W)
  ) u_br_eval (
    .mm_i    (mm_q),
    .stat_i  (bus.stat),
    .neg_i   (is_neg_branch(opcode_q)),
    .taken_o (taken)
  );

  // The mask MSB picks the ALU class for ALU instructions.
  assign alu_fn = mm_q[MM_W-1] ? ALU_LOGIC : ALU_ARITH;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RESET;
      opcode_q <= '0;
      mm_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        opcode_q <= bus.opcode;
        mm_q     <= bus.mm;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_load_d  = 1'b0;
    pc_write_d = 1'b0;
    pc_sel_d   = 1'b0;
    br_sel_d   = 1'b0;
    alu_op_d   = ALU_PASS;
    stat_en_d  = 1'b0;
    rf_we_d    = 1'b0;
    wb_sel_d   = WB_ALU;
    dm_we_d    = 1'b0;
    halted_d   = 1'b0;

    unique case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        ir_load_d  = 1'b1;
        pc_write_d = 1'b1;
        state_d    = S_DECODE;
      end

      S_DECODE: state_d = S_EXECUTE;

      S_EXECUTE: begin
        case (opcode_q)
          OP_ALU_RR, OP_ALU_IMM: begin
            alu_op_d  = alu_fn;
            stat_en_d = 1'b1;
            state_d   = S_WB;
          end
          OP_LOD, OP_STR: begin
            alu_op_d = ALU_PASS;
            state_d  = S_MEM;
          end
          OP_BRA, OP_BRR, OP_BNE, OP_BNR: begin
            if (taken) begin
              pc_write_d = 1'b1;
              pc_sel_d   = 1'b1;
              br_sel_d   = is_abs_branch(opcode_q);
            end
            state_d = S_FETCH;
          end
          OP_HLT:  state_d = S_HALT;
          OP_NOP:  state_d = S_FETCH;
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        // Address stays on the ALU so memory sees a stable address.
        alu_op_d = ALU_PASS;
        if (opcode_q == OP_STR) begin
          dm_we_d = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end

      S_WB: begin
        rf_we_d = 1'b1;
        case (opcode_q)
          OP_ALU_RR: begin
            wb_sel_d = WB_ALU;
            // Keep the ALU function so its result is still on the WB mux.
            alu_op_d = alu_fn;
          end
          OP_ALU_IMM: begin
            wb_sel_d = WB_IMM;
            alu_op_d = alu_fn;
          end
          default: wb_sel_d = WB_MEM;
        endcase
        state_d = S_FETCH;
      end

      S_HALT: halted_d = 1'b1;

      default: state_d = S_RESET;
    endcase
  end

  assign bus.ir_load  = ir_load_d;
  assign bus.pc_write = pc_write_d;
  assign bus.pc_sel   = pc_sel_d;
  assign bus.br_sel   = br_sel_d;
  assign bus.alu_op   = alu_op_d;
  assign bus.stat_en  = stat_en_d;
  assign bus.rf_we    = rf_we_d;
  assign bus.wb_sel   = wb_sel_d;
  assign bus.dm_we    = dm_we_d;
  assign bus.halted   = halted_d;

endmodule

// File: tb/tb_sisc_ctrl.sv
// tb_sisc_ctrl: directed bench for the SISC control FSM.
// Outputs are packed as {ir_load,pc_write,pc_sel,br_sel,alu_op[1:0],
// stat_en,rf_we,wb_sel[1:0],dm_we,halted} and compared per cycle against
// hand-derived vectors. Each test starts and ends in a FETCH cycle.
module tb_sisc_ctrl;
  import sisc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sisc_ctrl_if #(.OP_W(4), .MM_W(4), .STAT_W(4)) bus ();

  sisc_ctrl #(.OP_W(4), .MM_W(4), .STAT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [11:0] outs;
  assign outs = {bus.ir_load, bus.pc_write, bus.pc_sel, bus.br_sel, bus.alu_op,
                 bus.stat_en, bus.rf_we, bus.wb_sel, bus.dm_we, bus.halted};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned exp_latency(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'hC: return 4;
      4'h8:             return 5;
      default:          return 3;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.opcode = OP_NOP; bus.mm = 4'h0; bus.stat = 4'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (outs !== 12'h000) begin
        $display("FAIL reset_hold cyc%0d outs=%h exp=%h", i, outs, 12'h000);
        failures++;
      end
    end
    rst = 1'b0;
    checks++;
    if (outs !== 12'h000) begin
      $display("FAIL reset_rel1 outs=%h exp=%h", outs, 12'h000);
      failures++;
    end
    tick();
    checks++;
    if (outs !== 12'hC00) begin
      $display("FAIL reset_rel2_fetch outs=%h exp=%h", outs, 12'hC00);
      failures++;
    end
  endtask

  task automatic test_alu_rr();
    logic [11:0] exp [5];
    exp = '{12'hC00, 12'h000, 12'h060, 12'h050, 12'hC00};
    bus.opcode = OP_ALU_RR; bus.mm = 4'h0; bus.stat = 4'h0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (outs !== exp[i]) begin
        $display("FAIL alu_rr cyc%0d outs=%h exp=%h", i, outs, exp[i]);
        failures++;
      end
    end
  endtask

  task automatic test_alu_imm();
    logic [11:0] exp [5];
    exp = '{12'hC00, 12'h000, 12'h0A0, 12'h098, 12'hC00};
    bus.opcode = OP_ALU_IMM; bus.mm = 4'h8; bus.stat = 4'h0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (outs !== exp[i]) begin
        $display("FAIL alu_imm cyc%0d outs=%h exp=%h", i, outs, exp[i]);
        failures++;
      end
    end
  endtask

  task automatic test_lod_str();
    logic [11:0] exp_l [6];
    logic [11:0] exp_s [5];
    exp_l = '{12'hC00, 12'h000, 12'h000, 12'h000, 12'h014, 12'hC00};
    exp_s = '{12'hC00, 12'h000, 12'h000, 12'h002, 12'hC00};
    bus.opcode = OP_LOD; bus.mm = 4'h0; bus.stat = 4'h0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (outs !== exp_l[i]) begin
        $display("FAIL lod cyc%0d outs=%h exp=%h", i, outs, exp_l[i]);
        failures++;
      end
    end
    bus.opcode = OP_STR;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (outs !== exp_s[i]) begin
        $display("FAIL str cyc%0d outs=%h exp=%h", i, outs, exp_s[i]);
        failures++;
      end
    end
  endtask

  task automatic test_branch();
    // {opcode, mm, stat, expected EXECUTE outputs}
    logic [3:0]  op  [7];
    logic [3:0]  msk [7];
    logic [3:0]  st  [7];
    logic [11:0] ex  [7];
    op  = '{OP_BRA, OP_BRA, OP_BNR, OP_BRR, OP_BNE, OP_BRR, 4'h7};
    msk = '{4'h1,   4'h1,   4'h1,   4'h0,   4'h0,   4'h6,   4'hF};
    st  = '{4'h1,   4'h0,   4'h0,   4'hF,   4'hF,   4'h4,   4'hF};
    ex  = '{12'h700, 12'h000, 12'h600, 12'h000, 12'h700, 12'h600, 12'h000};
    for (int k = 0; k < 7; k++) begin
      bus.opcode = op[k]; bus.mm = msk[k]; bus.stat = st[k];
      tick();
      checks++;
      if (outs !== 12'h000) begin
        $display("FAIL br%0d_decode outs=%h exp=%h", k, outs, 12'h000);
        failures++;
      end
      tick();
      checks++;
      if (outs !== ex[k]) begin
        $display("FAIL br%0d_execute outs=%h exp=%h", k, outs, ex[k]);
        failures++;
      end
      tick();
      checks++;
      if (outs !== 12'hC00) begin
        $display("FAIL br%0d_refetch outs=%h exp=%h", k, outs, 12'hC00);
        failures++;
      end
    end
  endtask

  task automatic test_halt();
    bus.opcode = OP_HLT; bus.mm = 4'hF; bus.stat = 4'hF;
    tick();
    tick();
    checks++;
    if (outs !== 12'h000) begin
      $display("FAIL hlt_execute outs=%h exp=%h", outs, 12'h000);
      failures++;
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (outs !== 12'h001) begin
        $display("FAIL halted cyc%0d outs=%h exp=%h", i, outs, 12'h001);
        failures++;
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (outs !== 12'h000) begin
      $display("FAIL halt_reset outs=%h exp=%h", outs, 12'h000);
      failures++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if (outs !== 12'hC00) begin
      $display("FAIL halt_refetch outs=%h exp=%h", outs, 12'hC00);
      failures++;
    end
  endtask

  task automatic test_reset_mid_str();
    bus.opcode = OP_STR; bus.mm = 4'h0; bus.stat = 4'h0;
    tick();
    tick();
    tick();
    checks++;
    if (outs !== 12'h002) begin
      $display("FAIL midrst_mem outs=%h exp=%h", outs, 12'h002);
      failures++;
    end
    rst = 1'b1;
    tick();
    checks++;
    if (outs !== 12'h000) begin
      $display("FAIL midrst_cleared outs=%h exp=%h", outs, 12'h000);
      failures++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if (outs !== 12'hC00) begin
      $display("FAIL midrst_refetch outs=%h exp=%h", outs, 12'hC00);
      failures++;
    end
  endtask

  task automatic test_random_stream();
    logic [3:0]  cur_op = 4'h0;
    int unsigned since  = 0;
    bit          first  = 1'b1;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if ($countones({bus.rf_we, bus.dm_we, bus.ir_load}) > 1) begin
        $display("FAIL exclusive cyc%0d rf_we=%b dm_we=%b ir_load=%b exp=onehot0",
                 c, bus.rf_we, bus.dm_we, bus.ir_load);
        failures++;
      end
      if (bus.ir_load) begin
        if (!first) begin
          checks++;
          if (since != exp_latency(cur_op)) begin
            $display("FAIL latency op=%h got=%0d exp=%0d", cur_op, since,
                     exp_latency(cur_op));
            failures++;
          end
        end
        first  = 1'b0;
        cur_op = 4'($urandom_range(0, 14));
        bus.opcode = cur_op;
        bus.mm     = 4'($urandom);
        bus.stat   = 4'($urandom);
        since = 0;
      end else if (since > 8) begin
        checks++;
        failures++;
        $display("FAIL fetch_timeout op=%h waited=%0d exp<=5", cur_op, since);
        break;
      end
      tick();
      since++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_rr();
    test_alu_imm();
    test_lod_str();
    test_branch();
    test_halt();
    test_reset_mid_str();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
